rk_tape_tx: RTL and testbench

RK_TAPE_TX -- requirements
Module: rk_tape_tx

---
 rtl/rk_tape_tx_if.sv | 21 ++
 rtl/rk_tape_tx.sv | 246 ++++++++++++++++++++++++
 tb/tb_rk_tape_tx.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/rk_tape_tx_if.sv
// rtl/rk_tape_tx_if.sv - byte download handshake into the tape transmitter
interface rk_tape_tx_if;
    logic [7:0] din;
    logic       din_eof;
    logic       din_valid;
    logic       din_ready;

    modport master (
        output din,
        output din_eof,
        output din_valid,
        input  din_ready
    );

    modport slave (
        input  din,
        input  din_eof,
        input  din_valid,
        output din_ready
    );
endinterface

// File: rtl/rk_tape_tx.sv
// rtl/rk_tape_tx.sv - phase-encoded tape transmitter with input FIFO; RK_TAPE_PILOT_EN enables pilot/sync leader
module rk_tape_tx #(
    parameter int HALF_CELL   = 742,
    parameter int PILOT_BYTES = 256,
    parameter int FIFO_DEPTH  = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          ce,
    rk_tape_tx_if.slave   din_if,
    output logic          tape_out,
    output logic          busy,
    output logic          underrun
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int HW = $clog2(HALF_CELL + 1);
`ifdef RK_TAPE_PILOT_EN
    localparam int PW = $clog2(PILOT_BYTES + 1);
`endif

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        PILOT = 3'd1,
        SYNC  = 3'd2,
        DATA  = 3'd3,
        PAUSE = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic [8:0]    fifo_mem [FIFO_DEPTH];
    logic [AW:0]   wr_ptr_q, wr_ptr_d;
    logic [AW:0]   rd_ptr_q, rd_ptr_d;
    logic          din_ready_q, din_ready_d;
    logic [7:0]    shreg_q, shreg_d;
    logic          eof_byte_q, eof_byte_d;
    logic [2:0]    bit_idx_q, bit_idx_d;
    logic          half_q, half_d;
    logic [HW-1:0] hc_q, hc_d;
    logic          running_q, running_d;
    logic          tape_q, tape_d;
    logic          underrun_q, underrun_d;
`ifdef RK_TAPE_PILOT_EN
    logic [PW-1:0] pilot_cnt_q, pilot_cnt_d;
`endif

    logic          wr_en;
    logic          pop;
    logic          fifo_empty;
    logic [8:0]    rd_data;
    logic          byte_done;
    logic          load;
    logic [7:0]    load_val;
    logic          load_eof;

    assign wr_en      = din_if.din_valid & din_ready_q;
    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign rd_data    = fifo_mem[rd_ptr_q[AW-1:0]];

    assign din_if.din_ready = din_ready_q;
    assign tape_out         = tape_q;
    assign busy             = (state_q != IDLE);
    assign underrun         = underrun_q;

    // FIFO storage; pointers carry the empty/full information so no reset here
    always_ff @(posedge clk) begin
        if (wr_en && !reset) begin
            fifo_mem[wr_ptr_q[AW-1:0]] <= {din_if.din_eof, din_if.din};
        end
    end

    // State, FIFO pointers and bit-cell timing registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            din_ready_q <= 1'b0;
            shreg_q     <= '0;
            eof_byte_q  <= 1'b0;
            bit_idx_q   <= '0;
            half_q      <= 1'b0;
            hc_q        <= '0;
            running_q   <= 1'b0;
            tape_q      <= 1'b0;
            underrun_q  <= 1'b0;
`ifdef RK_TAPE_PILOT_EN
            pilot_cnt_q <= '0;
`endif
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            din_ready_q <= din_ready_d;
            shreg_q     <= shreg_d;
            eof_byte_q  <= eof_byte_d;
            bit_idx_q   <= bit_idx_d;
            half_q      <= half_d;
            hc_q        <= hc_d;
            running_q   <= running_d;
            tape_q      <= tape_d;
            underrun_q  <= underrun_d;
`ifdef RK_TAPE_PILOT_EN
            pilot_cnt_q <= pilot_cnt_d;
`endif
        end
    end

    // Half-cell sequencing, byte boundary decisions and FIFO pop
    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q + (AW + 1)'(wr_en);
        shreg_d    = shreg_q;
        eof_byte_d = eof_byte_q;
        bit_idx_d  = bit_idx_q;
        half_d     = half_q;
        hc_d       = hc_q;
        running_d  = running_q;
        tape_d     = tape_q;
        underrun_d = underrun_q;
`ifdef RK_TAPE_PILOT_EN
        pilot_cnt_d = pilot_cnt_q;
`endif
        pop       = 1'b0;
        byte_done = 1'b0;
        load      = 1'b0;
        load_val  = 8'h00;
        load_eof  = 1'b0;

        // Each ce advances the half-cell counter; level changes only when a half-cell ends
        if (ce && running_q) begin
            if (hc_q == HW'(HALF_CELL - 1)) begin
                hc_d = '0;
                if (!half_q) begin
                    half_d = 1'b1;
                    tape_d = shreg_q[7];
                end else if (bit_idx_q != 3'd7) begin
                    bit_idx_d = bit_idx_q + 3'd1;
                    shreg_d   = {shreg_q[6:0], 1'b0};
                    half_d    = 1'b0;
                    tape_d    = ~shreg_q[6];
                end else begin
                    byte_done = 1'b1;
                end
            end else begin
                hc_d = hc_q + HW'(1);
            end
        end

        case (state_q)
            IDLE: begin
                tape_d    = 1'b0;
                running_d = 1'b0;
                if (!fifo_empty) begin
`ifdef RK_TAPE_PILOT_EN
                    state_d     = PILOT;
                    pilot_cnt_d = '0;
`else
                    state_d     = DATA;
`endif
                end
            end
`ifdef RK_TAPE_PILOT_EN
            PILOT: begin
                if (ce && !running_q) begin
                    load     = 1'b1;
                    load_val = 8'h00;
                end else if (byte_done) begin
                    load = 1'b1;
                    if (pilot_cnt_q == PW'(PILOT_BYTES - 1)) begin
                        state_d  = SYNC;
                        load_val = 8'hE6;
                    end else begin
                        pilot_cnt_d = pilot_cnt_q + PW'(1);
                        load_val    = 8'h00;
                    end
                end
            end
            SYNC: begin
                if (byte_done) begin
                    if (!fifo_empty) begin
                        pop      = 1'b1;
                        load     = 1'b1;
                        load_val = rd_data[7:0];
                        load_eof = rd_data[8];
                        state_d  = DATA;
                    end else begin
                        state_d    = PAUSE;
                        running_d  = 1'b0;
                        underrun_d = 1'b1;
                    end
                end
            end
`endif
            DATA: begin
                if (ce && !running_q && !fifo_empty) begin
                    pop      = 1'b1;
                    load     = 1'b1;
                    load_val = rd_data[7:0];
                    load_eof = rd_data[8];
                end else if (byte_done) begin
                    if (eof_byte_q) begin
                        state_d    = IDLE;
                        tape_d     = 1'b0;
                        running_d  = 1'b0;
                        underrun_d = 1'b0;
                    end else if (!fifo_empty) begin
                        pop      = 1'b1;
                        load     = 1'b1;
                        load_val = rd_data[7:0];
                        load_eof = rd_data[8];
                    end else begin
                        state_d    = PAUSE;
                        running_d  = 1'b0;
                        underrun_d = 1'b1;
                    end
                end
            end
            PAUSE: begin
                if (ce && !fifo_empty) begin
                    pop      = 1'b1;
                    load     = 1'b1;
                    load_val = rd_data[7:0];
                    load_eof = rd_data[8];
                    state_d  = DATA;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A freshly loaded byte starts its first half-cell (~MSB) right away
        if (load) begin
            shreg_d    = load_val;
            eof_byte_d = load_eof;
            bit_idx_d  = 3'd0;
            half_d     = 1'b0;
            hc_d       = '0;
            running_d  = 1'b1;
            tape_d     = ~load_val[7];
        end

        rd_ptr_d    = rd_ptr_q + (AW + 1)'(pop);
        din_ready_d = ((wr_ptr_d - rd_ptr_d) != (AW + 1)'(FIFO_DEPTH));
    end
endmodule

// File: tb/tb_rk_tape_tx.sv
// tb/tb_rk_tape_tx.sv - directed self-checking bench for rk_tape_tx
module tb_rk_tape_tx;
    localparam int HC = 4;
    localparam int PB = 2;
    localparam int FD = 16;
`ifdef RK_TAPE_PILOT_EN
    localparam int NLEAD   = 3;
    localparam int RST_OFS = 148;
`else
    localparam int NLEAD   = 0;
    localparam int RST_OFS = 20;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic ce = 1'b1;
    logic tape_out, busy, underrun;

    rk_tape_tx_if bus ();

    rk_tape_tx #(
        .HALF_CELL  (HC),
        .PILOT_BYTES(PB),
        .FIFO_DEPTH (FD)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .ce      (ce),
        .din_if  (bus.slave),
        .tape_out(tape_out),
        .busy    (busy),
        .underrun(underrun)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int ce_div   = 0;
    int cyc      = 0;

    typedef struct {
        logic [7:0]  din;
        logic [15:0] halves;
    } frame_t;

    frame_t tbl [4];

    task automatic tick;
        @(posedge clk);
        #1;
        cyc++;
        if (ce_div != 0) ce = ((cyc % ce_div) == 0);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic check_halves(input string name, input logic [15:0] pat);
        for (int h = 15; h >= 0; h--) begin
            logic bad;
            bad = 1'b0;
            for (int k = 0; k < HC; k++) begin
                tick;
                if (tape_out !== pat[h]) bad = 1'b1;
            end
            chk($sformatf("%s half %0d level held", name, 15 - h), {31'b0, bad}, 32'd0);
        end
    endtask

    task automatic lead;
`ifdef RK_TAPE_PILOT_EN
        check_halves("pilot0", 16'hAAAA);
        check_halves("pilot1", 16'hAAAA);
        check_halves("sync", 16'h5696);
`endif
    endtask

    task automatic write_byte(input logic [7:0] d, input logic e);
        bus.din       = d;
        bus.din_eof   = e;
        bus.din_valid = 1'b1;
        tick;
        bus.din_valid = 1'b0;
        bus.din_eof   = 1'b0;
    endtask

    initial begin
        int n;
        int nt;
        int times [8];
        logic bad;
        logic prev;

        tbl[0] = '{din: 8'hA5, halves: 16'h6699};
        tbl[1] = '{din: 8'hFF, halves: 16'h5555};
        tbl[2] = '{din: 8'h00, halves: 16'hAAAA};
        tbl[3] = '{din: 8'h3C, halves: 16'hA55A};

        bus.din = 8'h00;
        bus.din_eof = 1'b0;
        bus.din_valid = 1'b0;
        reset = 1'b1;
        tick;
        tick;
        chk("reset din_ready", {31'b0, bus.din_ready}, 0);
        chk("reset tape_out", {31'b0, tape_out}, 0);
        chk("reset busy", {31'b0, busy}, 0);
        chk("reset underrun", {31'b0, underrun}, 0);
        reset = 1'b0;
        tick;
        chk("ready after release", {31'b0, bus.din_ready}, 1);
        chk("idle busy", {31'b0, busy}, 0);

        // single-byte images with eof
        for (int i = 0; i < 4; i++) begin
            write_byte(tbl[i].din, 1'b1);
            tick;
            chk($sformatf("frame %0d busy", i), {31'b0, busy}, 1);
            chk($sformatf("frame %0d tape idle low", i), {31'b0, tape_out}, 0);
            lead;
            check_halves($sformatf("frame %0h", tbl[i].din), tbl[i].halves);
            tick;
            chk($sformatf("frame %0d end tape", i), {31'b0, tape_out}, 0);
            chk($sformatf("frame %0d end busy", i), {31'b0, busy}, 0);
            chk($sformatf("frame %0d end underrun", i), {31'b0, underrun}, 0);
        end

        // underrun into PAUSE, then resume without pilot
        write_byte(8'h12, 1'b0);
        n = 0;
        while (!underrun && n < 2000) begin
            tick;
            n++;
        end
        chk("underrun latency", n, 2 + 64 * (NLEAD + 1));
        chk("pause busy", {31'b0, busy}, 1);
        bad = 1'b0;
        repeat (20) begin
            tick;
            if (tape_out !== 1'b0) bad = 1'b1;
        end
        chk("pause tape steady", {31'b0, bad}, 0);
        chk("underrun sticky", {31'b0, underrun}, 1);
        write_byte(8'h34, 1'b1);
        check_halves("resume 34", 16'hA59A);
        tick;
        chk("resume end busy", {31'b0, busy}, 0);
        chk("resume end tape", {31'b0, tape_out}, 0);
        chk("resume underrun cleared", {31'b0, underrun}, 0);

        // FIFO full with the FSM stalled
        ce = 1'b0;
        bus.din_valid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            bus.din = 8'(i);
            bus.din_eof = 1'b0;
            tick;
        end
        chk("full ready low", {31'b0, bus.din_ready}, 0);
        bus.din = 8'd16;
        bus.din_eof = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick;
            chk($sformatf("17th held %0d", i), {31'b0, bus.din_ready}, 0);
        end
        ce = 1'b1;
        n = 0;
        while (!bus.din_ready && n < 1000) begin
            tick;
            n++;
        end
        ce = 1'b0;
        chk("ce ticks to first pop", n, NLEAD * 64 + 1);
        tick;
        bus.din_valid = 1'b0;
        bus.din_eof = 1'b0;
        chk("17th accepted", {31'b0, bus.din_ready}, 0);
        ce = 1'b1;
        n = 0;
        while (busy && n < 3000) begin
            tick;
            n++;
        end
        chk("17 bytes drain time", n, 1088);
        chk("drain no underrun", {31'b0, underrun}, 0);

        // reset in the middle of a bit
        write_byte(8'h55, 1'b0);
        write_byte(8'h66, 1'b0);
        repeat (RST_OFS) tick;
        chk("pre-reset busy", {31'b0, busy}, 1);
        reset = 1'b1;
        bus.din = 8'h77;
        bus.din_eof = 1'b1;
        bus.din_valid = 1'b1;
        tick;
        chk("mid reset tape", {31'b0, tape_out}, 0);
        chk("mid reset busy", {31'b0, busy}, 0);
        chk("mid reset ready", {31'b0, bus.din_ready}, 0);
        chk("mid reset underrun", {31'b0, underrun}, 0);
        tick;
        reset = 1'b0;
        bus.din_valid = 1'b0;
        bus.din_eof = 1'b0;
        tick;
        chk("ready after mid reset", {31'b0, bus.din_ready}, 1);
        repeat (4) tick;
        chk("fifo emptied by reset", {31'b0, busy}, 0);
        chk("tape low after reset", {31'b0, tape_out}, 0);

        // ce every third clock
        ce_div = 3;
        write_byte(8'h00, 1'b1);
        prev = tape_out;
        nt = 0;
        for (int i = 0; i < 8; i++) times[i] = 0;
        for (int i = 0; i < 3000; i++) begin
            tick;
            if (tape_out !== prev) begin
                if (nt < 8) times[nt] = i;
                nt++;
                prev = tape_out;
            end
            if (!busy) break;
        end
        for (int j = 0; j < 4; j++)
            chk($sformatf("ce/3 half-cell %0d clocks", j), times[j + 1] - times[j], 12);
        chk("ce/3 frame ends", {31'b0, busy}, 0);
        ce_div = 0;
        ce = 1'b1;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
